// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control bus between multicycle_ctrl and the CPU datapath
interface multicycle_ctrl_if;
  logic [31:0] ir;
  logic        br_taken;
  logic        ir_we;
  logic        ab_we;
  logic        y_we;
  logic        mdr_we;
  logic        rf_we;
  logic        mem_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [1:0]  alu_src1_sel;
  logic [1:0]  alu_src2_sel;
  logic        alu_op;
  logic [1:0]  wb_sel;

  modport master (
    input  ir, br_taken,
    output ir_we, ab_we, y_we, mdr_we, rf_we, mem_we, pc_we,
    output pc_sel, alu_src1_sel, alu_src2_sel, alu_op, wb_sel
  );

  modport slave (
    output ir, br_taken,
    input  ir_we, ab_we, y_we, mdr_we, rf_we, mem_we, pc_we,
    input  pc_sel, alu_src1_sel, alu_src2_sel, alu_op, wb_sel
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - decoded IF/ID/EX/MEM/WB sequencer for the multi-cycle LoongArch datapath
module multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 cpu_clk,
  input  logic                 rstn,
  input  logic                 run,
  input  logic                 step,
  multicycle_ctrl_if.master    bus,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_ADDI, C_LU12I, C_LD, C_ST,
    C_JIRL, C_B, C_BL, C_BR, C_HALT, C_ILL
  } cls_t;

  state_t st;
  cls_t   cls;

  always_comb begin
    cls = C_ILL;
    if (bus.ir == 32'h0)                                  cls = C_HALT;
    else if (bus.ir[31:15] == 17'h00020)                  cls = C_ADD;
    else if (bus.ir[31:15] == 17'h00022)                  cls = C_SUB;
    else if (bus.ir[31:22] == 10'h00A)                    cls = C_ADDI;
    else if (bus.ir[31:25] == 7'h0A)                      cls = C_LU12I;
    else if (bus.ir[31:22] == 10'h0A2)                    cls = C_LD;
    else if (bus.ir[31:22] == 10'h0A6)                    cls = C_ST;
    else if (bus.ir[31:26] == 6'h13)                      cls = C_JIRL;
    else if (bus.ir[31:26] == 6'h14)                      cls = C_B;
    else if (bus.ir[31:26] == 6'h15)                      cls = C_BL;
    else if (bus.ir[31:26] >= 6'h16 && bus.ir[31:26] <= 6'h1B) cls = C_BR;
  end

  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      st        <= S_IDLE;
      illegal   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      case (st)
        S_IDLE: if (run || step) st <= S_IF;
        S_IF:   st <= S_ID;
        S_ID: begin
          if (cls == C_HALT) begin
            st <= S_IDLE;
          end else if (cls == C_ILL) begin
            st      <= S_ERR;
            illegal <= 1'b1;
          end else begin
            st <= S_EX;
          end
        end
        S_EX:  st <= (cls == C_LD || cls == C_ST) ? S_MEM : S_WB;
        S_MEM: st <= S_WB;
        S_WB: begin
          instr_cnt <= instr_cnt + CNT_WIDTH'(1);
          st        <= run ? S_IF : S_IDLE;
        end
        S_ERR:   st <= S_ERR;
        default: st <= S_IDLE;
      endcase
    end
  end

  logic       ir_we_d, ab_we_d, y_we_d, mdr_we_d, rf_we_d, mem_we_d, pc_we_d;
  logic [1:0] pc_sel_d, src1_d, src2_d, wb_sel_d;
  logic       alu_op_d;

  always_comb begin
    ir_we_d  = 1'b0;
    ab_we_d  = 1'b0;
    y_we_d   = 1'b0;
    mdr_we_d = 1'b0;
    rf_we_d  = 1'b0;
    mem_we_d = 1'b0;
    pc_we_d  = 1'b0;
    pc_sel_d = 2'd0;
    src1_d   = 2'd0;
    src2_d   = 2'd0;
    alu_op_d = 1'b0;
    wb_sel_d = 2'd0;
    case (st)
      S_IF: ir_we_d = 1'b1;
      S_ID: ab_we_d = 1'b1;
      S_EX: begin
        case (cls)
          C_ADD: y_we_d = 1'b1;
          C_SUB: begin
            y_we_d   = 1'b1;
            alu_op_d = 1'b1;
          end
          C_ADDI, C_LD, C_ST, C_JIRL: begin
            y_we_d = 1'b1;
            src2_d = 2'd1;
          end
          C_LU12I: begin
            y_we_d = 1'b1;
            src1_d = 2'd2;
            src2_d = 2'd1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mdr_we_d = (cls == C_LD);
        mem_we_d = (cls == C_ST);
      end
      S_WB: begin
        pc_we_d = 1'b1;
        case (cls)
          C_ADD, C_SUB, C_ADDI, C_LU12I: rf_we_d = 1'b1;
          C_LD: begin
            rf_we_d  = 1'b1;
            wb_sel_d = 2'd1;
          end
          C_JIRL: begin
            rf_we_d  = 1'b1;
            wb_sel_d = 2'd2;
            pc_sel_d = 2'd2;
          end
          C_B:  pc_sel_d = 2'd1;
          C_BL: begin
            rf_we_d  = 1'b1;
            wb_sel_d = 2'd2;
            pc_sel_d = 2'd1;
          end
          C_BR: pc_sel_d = bus.br_taken ? 2'd1 : 2'd0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Write enables are gated by rstn so a reset landing mid-MEM/WB never commits state.
  assign bus.ir_we        = ir_we_d  & rstn;
  assign bus.ab_we        = ab_we_d  & rstn;
  assign bus.y_we         = y_we_d   & rstn;
  assign bus.mdr_we       = mdr_we_d & rstn;
  assign bus.rf_we        = rf_we_d  & rstn;
  assign bus.mem_we       = mem_we_d & rstn;
  assign bus.pc_we        = pc_we_d  & rstn;
  assign bus.pc_sel       = pc_sel_d;
  assign bus.alu_src1_sel = src1_d;
  assign bus.alu_src2_sel = src2_d;
  assign bus.alu_op       = alu_op_d;
  assign bus.wb_sel       = wb_sel_d;

  assign state = st;
  assign busy  = (st == S_IF) || (st == S_ID) || (st == S_EX) || (st == S_MEM) || (st == S_WB);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic        cpu_clk = 1'b0;
  logic        rstn;
  logic        run;
  logic        step;
  logic [2:0]  state;
  logic        busy;
  logic        illegal;
  logic [31:0] instr_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_cnt = 32'd0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.CNT_WIDTH(32)) dut (
    .cpu_clk   (cpu_clk),
    .rstn      (rstn),
    .run       (run),
    .step      (step),
    .bus       (bus),
    .state     (state),
    .busy      (busy),
    .illegal   (illegal),
    .instr_cnt (instr_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  // {state, busy, ir/ab/y/mdr/rf/mem/pc we, pc_sel, src1, src2, alu_op, wb_sel}
  wire [19:0] ctl = {state, busy, bus.ir_we, bus.ab_we, bus.y_we, bus.mdr_we, bus.rf_we,
                     bus.mem_we, bus.pc_we, bus.pc_sel, bus.alu_src1_sel, bus.alu_src2_sel,
                     bus.alu_op, bus.wb_sel};

  function automatic logic [19:0] mk(input logic [2:0] st, input logic bz, input logic [6:0] en,
                                     input logic [1:0] pcs, input logic [1:0] s1,
                                     input logic [1:0] s2, input logic op, input logic [1:0] wbs);
    return {st, bz, en, pcs, s1, s2, op, wbs};
  endfunction

  localparam logic [19:0] V_IDLE    = mk(3'd0, 1'b0, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [19:0] V_IF      = mk(3'd1, 1'b1, 7'b1000000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [19:0] V_ID      = mk(3'd2, 1'b1, 7'b0100000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [19:0] V_EX_IMM  = mk(3'd3, 1'b1, 7'b0010000, 2'd0, 2'd0, 2'd1, 1'b0, 2'd0);
  localparam logic [19:0] V_EX_BR   = mk(3'd3, 1'b1, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [19:0] V_WB_ALU  = mk(3'd5, 1'b1, 7'b0000101, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [19:0] V_MEM_ST  = mk(3'd4, 1'b1, 7'b0000010, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
  localparam logic [19:0] V_ERR     = mk(3'd6, 1'b0, 7'b0000000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);

  localparam logic [31:0] I_ADDI = 32'h02801401;
  localparam logic [31:0] I_ST   = 32'h29800000;

  task automatic tick;
    @(negedge cpu_clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0; run = 1'b0; step = 1'b0; bus.ir = 32'h0; bus.br_taken = 1'b0;
    repeat (2) tick();
    total_cnt++;
    if (ctl !== 20'h0) $display("FAIL reset_ctl: got %h expected %h", ctl, 20'h0);
    else pass_cnt++;
    total_cnt++;
    if (instr_cnt !== 32'd0 || illegal !== 1'b0)
      $display("FAIL reset_cnt_illegal: got cnt=%0d ill=%b expected cnt=0 ill=0", instr_cnt, illegal);
    else pass_cnt++;
    rstn = 1'b1;
    tick();
    total_cnt++;
    if (ctl !== V_IDLE) $display("FAIL idle_hold: got %h expected %h", ctl, V_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_run_back_to_back;
    logic [19:0] seq [0:8];
    logic [31:0] cnt_seq [0:8];
    seq[0] = V_IF; seq[1] = V_ID; seq[2] = V_EX_IMM; seq[3] = V_WB_ALU;
    seq[4] = V_IF; seq[5] = V_ID; seq[6] = V_EX_IMM; seq[7] = V_WB_ALU; seq[8] = V_IDLE;
    cnt_seq[0] = 0; cnt_seq[1] = 0; cnt_seq[2] = 0; cnt_seq[3] = 0;
    cnt_seq[4] = 1; cnt_seq[5] = 1; cnt_seq[6] = 1; cnt_seq[7] = 1; cnt_seq[8] = 2;
    bus.ir = I_ADDI;
    run = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 4) run = 1'b0;
      total_cnt++;
      if (ctl !== seq[k] || instr_cnt !== cnt_seq[k])
        $display("FAIL run_addi cyc%0d: got ctl=%h cnt=%0d expected ctl=%h cnt=%0d",
                 k, ctl, instr_cnt, seq[k], cnt_seq[k]);
      else pass_cnt++;
    end
    exp_cnt = 32'd2;
  endtask

  task automatic test_instr_table;
    logic [31:0] irs  [0:7];
    logic        tks  [0:7];
    logic        hm   [0:7];
    logic [19:0] exs  [0:7];
    logic [19:0] mems [0:7];
    logic [19:0] wbs  [0:7];
    irs[0] = 32'h28800000; tks[0] = 0; hm[0] = 1; exs[0] = V_EX_IMM;
    mems[0] = mk(3'd4, 1'b1, 7'b0001000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
    wbs[0]  = mk(3'd5, 1'b1, 7'b0000101, 2'd0, 2'd0, 2'd0, 1'b0, 2'd1);
    irs[1] = I_ST; tks[1] = 0; hm[1] = 1; exs[1] = V_EX_IMM; mems[1] = V_MEM_ST;
    wbs[1]  = mk(3'd5, 1'b1, 7'b0000001, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
    irs[2] = 32'h58000000; tks[2] = 1; hm[2] = 0; exs[2] = V_EX_BR; mems[2] = 20'h0;
    wbs[2]  = mk(3'd5, 1'b1, 7'b0000001, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0);
    irs[3] = 32'h58000000; tks[3] = 0; hm[3] = 0; exs[3] = V_EX_BR; mems[3] = 20'h0;
    wbs[3]  = mk(3'd5, 1'b1, 7'b0000001, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
    irs[4] = 32'h54000000; tks[4] = 0; hm[4] = 0; exs[4] = V_EX_BR; mems[4] = 20'h0;
    wbs[4]  = mk(3'd5, 1'b1, 7'b0000101, 2'd1, 2'd0, 2'd0, 1'b0, 2'd2);
    irs[5] = 32'h00110000; tks[5] = 0; hm[5] = 0; mems[5] = 20'h0;
    exs[5]  = mk(3'd3, 1'b1, 7'b0010000, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0);
    wbs[5]  = V_WB_ALU;
    irs[6] = 32'h14000000; tks[6] = 0; hm[6] = 0; mems[6] = 20'h0;
    exs[6]  = mk(3'd3, 1'b1, 7'b0010000, 2'd0, 2'd2, 2'd1, 1'b0, 2'd0);
    wbs[6]  = V_WB_ALU;
    irs[7] = 32'h4C000000; tks[7] = 0; hm[7] = 0; exs[7] = V_EX_IMM; mems[7] = 20'h0;
    wbs[7]  = mk(3'd5, 1'b1, 7'b0000101, 2'd2, 2'd0, 2'd0, 1'b0, 2'd2);
    for (int i = 0; i < 8; i++) begin
      bus.ir = irs[i];
      bus.br_taken = tks[i];
      step = 1'b1;
      tick();
      step = 1'b0;
      total_cnt++;
      if (ctl !== V_IF) $display("FAIL instr%0d_if: got %h expected %h", i, ctl, V_IF);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ctl !== V_ID) $display("FAIL instr%0d_id: got %h expected %h", i, ctl, V_ID);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ctl !== exs[i]) $display("FAIL instr%0d_ex: got %h expected %h", i, ctl, exs[i]);
      else pass_cnt++;
      if (hm[i]) begin
        tick();
        total_cnt++;
        if (ctl !== mems[i]) $display("FAIL instr%0d_mem: got %h expected %h", i, ctl, mems[i]);
        else pass_cnt++;
      end
      tick();
      total_cnt++;
      if (ctl !== wbs[i]) $display("FAIL instr%0d_wb: got %h expected %h", i, ctl, wbs[i]);
      else pass_cnt++;
      tick();
      exp_cnt = exp_cnt + 32'd1;
      total_cnt++;
      if (ctl !== V_IDLE || instr_cnt !== exp_cnt)
        $display("FAIL instr%0d_retire: got ctl=%h cnt=%0d expected ctl=%h cnt=%0d",
                 i, ctl, instr_cnt, V_IDLE, exp_cnt);
      else pass_cnt++;
    end
    bus.br_taken = 1'b0;
  endtask

  task automatic test_step_ignored;
    logic [19:0] seq [0:5];
    seq[0] = V_IF; seq[1] = V_ID; seq[2] = V_EX_IMM; seq[3] = V_WB_ALU;
    seq[4] = V_IDLE; seq[5] = V_IDLE;
    bus.ir = I_ADDI;
    step = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      step = (k == 2);
      total_cnt++;
      if (ctl !== seq[k]) $display("FAIL step_ignored cyc%0d: got %h expected %h", k, ctl, seq[k]);
      else pass_cnt++;
    end
    exp_cnt = exp_cnt + 32'd1;
    total_cnt++;
    if (instr_cnt !== exp_cnt) $display("FAIL step_cnt: got %0d expected %0d", instr_cnt, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_halt;
    bus.ir = 32'h0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    total_cnt++;
    if (ctl !== V_ID) $display("FAIL halt_id: got %h expected %h", ctl, V_ID);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ctl !== V_IDLE || instr_cnt !== exp_cnt)
      $display("FAIL halt_idle: got ctl=%h cnt=%0d expected ctl=%h cnt=%0d", ctl, instr_cnt, V_IDLE, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_mem;
    bus.ir = I_ST;
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if (ctl !== V_MEM_ST) $display("FAIL st_mem: got %h expected %h", ctl, V_MEM_ST);
    else pass_cnt++;
    rstn = 1'b0;
    #1;
    total_cnt++;
    if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we);
    else pass_cnt++;
    tick();
    exp_cnt = 32'd0;
    total_cnt++;
    if (ctl !== V_IDLE || instr_cnt !== exp_cnt)
      $display("FAIL rst_mid_mem: got ctl=%h cnt=%0d expected ctl=%h cnt=0", ctl, instr_cnt, V_IDLE);
    else pass_cnt++;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_illegal;
    bus.ir = 32'hFFFFFFFF;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    total_cnt++;
    if (ctl !== V_ID || illegal !== 1'b0)
      $display("FAIL ill_id: got ctl=%h ill=%b expected ctl=%h ill=0", ctl, illegal, V_ID);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ctl !== V_ERR || illegal !== 1'b1)
      $display("FAIL ill_err: got ctl=%h ill=%b expected ctl=%h ill=1", ctl, illegal, V_ERR);
    else pass_cnt++;
    run = 1'b1;
    step = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if (ctl !== V_ERR || illegal !== 1'b1 || instr_cnt !== exp_cnt)
      $display("FAIL ill_hold: got ctl=%h ill=%b cnt=%0d expected ctl=%h ill=1 cnt=%0d",
               ctl, illegal, instr_cnt, V_ERR, exp_cnt);
    else pass_cnt++;
    run = 1'b0;
    step = 1'b0;
    rstn = 1'b0;
    tick();
    total_cnt++;
    if (ctl !== V_IDLE || illegal !== 1'b0)
      $display("FAIL ill_reset: got ctl=%h ill=%b expected ctl=%h ill=0", ctl, illegal, V_IDLE);
    else pass_cnt++;
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_run_back_to_back();
    test_instr_table();
    test_step_ignored();
    test_halt();
    test_reset_mid_mem();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
